// File: rtl/crypto_fu_pkg.sv
// crypto_fu_pkg: op indices, FU strobe count and issue FSM states for crypto_fu_issue
package crypto_fu_pkg;
  localparam int NUM_OPS = 21;
  localparam int OP_LUT4LO = 0;
  localparam int OP_SAES32_ENCS = 3;
  localparam int OP_SSHA512_SUM1R = 12;
  localparam int OP_SSM4_ED = 20;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_e;
endpackage

// File: rtl/crypto_op_onehot.sv
// crypto_op_onehot: op index to one-hot FU strobe, flagging indices past the last op
module crypto_op_onehot
  import crypto_fu_pkg::*;
(
  input  logic [4:0]         idx_i,
  output logic [NUM_OPS-1:0] onehot_o,
  output logic               illegal_o
);
  always_comb begin
    illegal_o = idx_i > 5'(OP_SSM4_ED);
    onehot_o  = illegal_o ? '0 : {{(NUM_OPS-1){1'b0}}, 1'b1} << idx_i;
  end
endmodule

// File: rtl/crypto_fu_issue.sv
// crypto_fu_issue: issues one crypto op to the FU, stalls the core, returns a write-back pulse
module crypto_fu_issue
  import crypto_fu_pkg::*;
#(
  parameter int MAX_WAIT = 64
)
(
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic               req_valid,
  input  logic [4:0]         req_op,
  input  logic [31:0]        req_rs1,
  input  logic [31:0]        req_rs2,
  input  logic [3:0]         req_imm,
  input  logic [4:0]         req_rd,
  input  logic               flush,
  output logic               stall,
  output logic               wb_en,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               illegal_op,
  output logic               busy,
  output logic               fu_valid,
  output logic [NUM_OPS-1:0] fu_op,
  output logic [31:0]        fu_rs1,
  output logic [31:0]        fu_rs2,
  output logic [3:0]         fu_imm,
  input  logic               fu_ready,
  input  logic [31:0]        fu_rd
`ifdef CRYPTO_FU_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);
  state_e             state_q, state_d;
  logic [NUM_OPS-1:0] op_oh, fu_op_q, fu_op_d;
  logic               op_ill, accept, inflight, tmo, illegal_q;
  logic [31:0]        rs1_q, rs2_q, wb_data_q;
  logic [3:0]         imm_q;
  logic [4:0]         rd_q;

  crypto_op_onehot u_onehot (
    .idx_i     (req_op),
    .onehot_o  (op_oh),
    .illegal_o (op_ill)
  );

  assign accept   = state_q == IDLE && req_valid && !flush && !op_ill;
  assign inflight = state_q == REQ || state_q == WAIT;

`ifdef CRYPTO_FU_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       tmo_q;
  assign tmo = (inflight || state_q == DRAIN) && !fu_ready && cnt_q == 8'(MAX_WAIT - 1);
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= accept ? '0 : (inflight || state_q == DRAIN) ? cnt_q + 8'd1 : cnt_q;
      tmo_q <= tmo;
    end
  end
  assign timeout_err = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = accept ? REQ : IDLE;
      REQ, WAIT: state_d = fu_ready ? (flush ? IDLE : RESP) : (flush ? DRAIN : WAIT);
      RESP:      state_d = IDLE;
      DRAIN:     state_d = fu_ready ? IDLE : DRAIN;
      default:   state_d = IDLE;
    endcase
    if (tmo) state_d = IDLE;
    fu_op_d = accept ? op_oh : (state_d == REQ || state_d == WAIT || state_d == DRAIN) ? fu_op_q : '0;
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q   <= IDLE;
      fu_op_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fu_op_q   <= fu_op_d;
      illegal_q <= state_q == IDLE && req_valid && !flush && op_ill;
      if (accept) begin
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
        imm_q <= req_imm;
        rd_q  <= req_rd;
      end
      if (inflight && fu_ready && !flush) wb_data_q <= fu_rd;
    end
  end

  assign stall      = accept || inflight;
  assign busy       = state_q != IDLE;
  assign fu_valid   = state_q == REQ;
  assign wb_en      = state_q == RESP && !flush;
  assign wb_rd      = rd_q;
  assign wb_data    = wb_data_q;
  assign illegal_op = illegal_q;
  assign fu_op      = fu_op_q;
  assign fu_rs1     = rs1_q;
  assign fu_rs2     = rs2_q;
  assign fu_imm     = imm_q;
endmodule
